// File: rtl/fifo_status_ctrl.sv
// Registered pointer, occupancy and status-flag controller for a single-clock,
// power-of-two FIFO. It drives the storage RAM addresses and gates its strobes.
module fifo_status_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          flag_clr,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          wr_accept,
  output logic          rd_accept,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  // Accepts depend only on requests and registered flags, so the RAM sees a
  // strobe in the same cycle; reset holds both strobes off.
  assign wr_accept = reset & wr_en & ~full_q;
  assign rd_accept = reset & rd_en & ~empty_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_accept);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_accept);
    count_d  = count_q + (AW+1)'(wr_accept) - (AW+1)'(rd_accept);
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
    // A new error in the same cycle as flag_clr must not be lost.
    ovf_d    = (wr_en & full_q) | (ovf_q & ~flag_clr);
    unf_d    = (rd_en & empty_q) | (unf_q & ~flag_clr);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_addr      = wr_ptr_q[AW-1:0];
  assign rd_addr      = rd_ptr_q[AW-1:0];
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Scoreboard bench for fifo_status_ctrl (FIFO_DEPTH=8, AF_LEVEL=7, AE_LEVEL=1):
// stimulus pushes expected observations, a negedge monitor pops and compares.
module tb_fifo_status_ctrl;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, flag_clr = 1'b0;
  logic [2:0] wr_addr, rd_addr;
  logic       wr_accept, rd_accept;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  fifo_status_ctrl #(.FIFO_DEPTH(D), .AF_LEVEL(7), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .flag_clr(flag_clr),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_accept(wr_accept), .rd_accept(rd_accept),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count, wp, rp, ovf, unf, wa, ra, hc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: occupancy plus free-running pointers mod 2*D.
  int m_count = 0, m_wp = 0, m_rp = 0, m_ovf = 0, m_unf = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs; hc is an optional hand-computed count for the
  // state visible during this cycle.
  task automatic step(input bit wr, input bit rd, input bit clr = 1'b0,
                      input bit rstn = 1'b1, input int hc = -1);
    exp_t e;
    int   wa, ra;
    wr_en = wr; rd_en = rd; flag_clr = clr; reset = rstn;
    wa = (rstn && wr && m_count != D) ? 1 : 0;
    ra = (rstn && rd && m_count != 0) ? 1 : 0;
    e = '{count: m_count, wp: m_wp, rp: m_rp, ovf: m_ovf, unf: m_unf,
          wa: wa, ra: ra, hc: hc};
    q.push_back(e);
    if (!rstn) begin
      m_count = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf   = ((wr && m_count == D) || (m_ovf != 0 && !clr)) ? 1 : 0;
      m_unf   = ((rd && m_count == 0) || (m_unf != 0 && !clr)) ? 1 : 0;
      m_count = m_count + wa - ra;
      m_wp    = (m_wp + wa) % (2 * D);
      m_rp    = (m_rp + ra) % (2 * D);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    int   wp, rp;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e  = q.pop_front();
        wp = int'(dut.wr_ptr_q);
        rp = int'(dut.rd_ptr_q);
        check("count", int'(count), e.count);
        if (e.hc >= 0) check("count_hand", int'(count), e.hc);
        check("full", int'(full), (e.count == D) ? 1 : 0);
        check("empty", int'(empty), (e.count == 0) ? 1 : 0);
        check("almost_full", int'(almost_full), (e.count >= 7) ? 1 : 0);
        check("almost_empty", int'(almost_empty), (e.count <= 1) ? 1 : 0);
        check("overflow", int'(overflow), e.ovf);
        check("underflow", int'(underflow), e.unf);
        check("wr_addr", int'(wr_addr), e.wp % D);
        check("rd_addr", int'(rd_addr), e.rp % D);
        check("wr_accept", int'(wr_accept), e.wa);
        check("rd_accept", int'(rd_accept), e.ra);
        check("wr_ptr", wp, e.wp);
        check("rd_ptr", rp, e.rp);
        check("ptr_diff_count", (wp - rp + 2 * D) % (2 * D), int'(count));
        check("full_ptr_form", int'(full),
              ((wp / D) != (rp / D) && (wp % D) == (rp % D)) ? 1 : 0);
        check("empty_ptr_form", int'(empty), (wp == rp) ? 1 : 0);
      end
    end
  end

  initial begin : stimulus
    int budget;
    // Initial reset: DUT state is unknown before it, so nothing is queued.
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Idle after reset.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Fill: 8 writes, then a rejected 9th write and overflow handling.
    for (int i = 0; i < D; i++) step(1, 0, 0, 1, i);
    step(1, 0, 0, 1, 8);
    step(0, 0, 0, 1, 8);
    step(0, 0, 1, 1, 8);
    step(0, 0, 0, 1, 8);

    // From full: simultaneous write/read accepts only the read.
    step(1, 1, 0, 1, 8);
    step(0, 0, 0, 1, 7);
    for (int i = 7; i > 4; i--) step(0, 1, 0, 1, i);
    step(1, 1, 0, 1, 4);
    step(0, 0, 0, 1, 4);

    // Drain, underflow, and set-wins-over-clear.
    for (int i = 4; i > 0; i--) step(0, 1, 0, 1, i);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);

    // From empty: simultaneous write/read accepts only the write.
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1);

    // Wrap: 20 write/read pairs with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      repeat ($urandom_range(0, 2)) step(0, 0);
      step(0, 1);
      repeat ($urandom_range(0, 1)) step(0, 0);
    end

    // Build to 5 entries, then reset mid-burst with wr_en held high.
    step(1, 1);
    for (int i = 0; i < 4; i++) step(1, 0);
    step(0, 0, 0, 1, 5);
    step(1, 0, 0, 0, 5);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    budget = 0;
    while (q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() != 0) check("scoreboard_drain", q.size(), 0);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
